l2_port_arbiter: RTL
====================

// Module: l2_port_arbiter
// PURPOSE
//  Shares the single L2 port between the instruction cache (line refills) and the data cache
//  (refills and dirty-line writebacks). Latches the one-cycle request pulses from each cache,
//  grants one requester at a time, runs one L2 transaction to completion, and routes the
//  response pulse back to the owner. Sits between Icache/Dcache and the L2 controller.
// PARAMETERS
//  ADDR_WIDTH    32    byte address width
//  OFFSET_WIDTH  7     line offset bits; line address = ADDR_WIDTH-OFFSET_WIDTH bits
//  LINE_WIDTH    1024  cache line width in bits (32 words x 32 b)
//  AGE_MAX       4     consecutive D grants while I is pending before I is forced to win
// PORTS
//  CLK           in   1      clock
//  RST           in   1      reset, asynchronous, active-high
//  I_REQ         in   1      Icache request pulse (Icache ADDR_TO_L2_VALID)
//  I_ADDR        in   LA     Icache line address, LA = ADDR_WIDTH-OFFSET_WIDTH
//  I_FLUSH       in   1      Icache flush; drops a pending, not yet granted, I request
//  I_RVALID      out  1      one-cycle refill-done pulse to Icache (DATA_FROM_L2_VALID)
//  D_REQ         in   1      Dcache request pulse
//  D_WR          in   1      qualifies D_REQ: 1 = writeback, 0 = refill
//  D_ADDR        in   LA     Dcache line address
//  D_WDATA       in   LINE_WIDTH  writeback line, sampled with D_REQ
//  D_RVALID      out  1      one-cycle refill-done pulse to Dcache
//  D_WDONE       out  1      one-cycle writeback-done pulse to Dcache
//  D_BUSY        out  1      high while a D writeback is pending or granted (Icache DCACHE_flusing)
//  RDATA         out  LINE_WIDTH  registered L2 read line, valid with I_RVALID/D_RVALID
//  L2_REQ        out  1      request to L2, held until L2_ACCEPT
//  L2_WR         out  1      1 = write transaction
//  L2_ADDR       out  LA     line address to L2
//  L2_WDATA      out  LINE_WIDTH  write line to L2
//  L2_ACCEPT     in   1      L2 accepts request this cycle (L2_REQ & L2_ACCEPT = handshake)
//  L2_RVALID     in   1      read data valid pulse
//  L2_RDATA      in   LINE_WIDTH  read data
//  L2_WACK       in   1      write complete pulse
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, pending flags clear, age counter 0, RDATA 0.
//  - Pending latches: I_REQ/D_REQ pulse sets pend flag and captures addr (+D_WR, D_WDATA) at that
//    edge. Pulse while same requester already pending or granted: ignored, first capture kept.
//    Set and clear in same cycle: set wins (new request stays pending).
//  - I_FLUSH: clears I pend if not granted; a granted I transaction runs to completion.
//  - FSM IDLE -> ISSUE: any pend set; grant registered at that edge. Arbitration: D wins unless
//    I pend and age == AGE_MAX. Age increments on each D grant with I pending, clears on I grant;
//    saturates at AGE_MAX.
//  - ISSUE: L2_REQ=1 with L2_WR/L2_ADDR/L2_WDATA from granted latch, stable until L2_ACCEPT;
//    on handshake clear owner's pend, go WAIT.
//  - WAIT: read -> on L2_RVALID capture L2_RDATA into RDATA; write -> on L2_WACK. Go RESP.
//  - RESP: exactly one cycle; owner's I_RVALID / D_RVALID / D_WDONE = 1; -> IDLE (or ISSUE
//    next edge if pending). Min latency request pulse -> response pulse: 4 cycles + L2 latency.
//  - L2_RVALID/L2_WACK outside WAIT, or wrong type for transaction: ignored, no output pulse.
//  - D_BUSY = (D pend & D_WR) | (granted D & L2_WR), combinational from registers.
//  - Reset mid-transaction: everything aborts to reset values; late L2 responses are dropped.
// STRUCTURE
//  - Package l2_arb_pkg: state enum {IDLE, ISSUE, WAIT, RESP}, requester ids REQ_I/REQ_D,
//    default widths.
//  - Sub-module l2_req_latch (pend flag + addr/wr/wdata capture, set-wins rule), instantiated
//    once per requester (I instance ties wr=0, wdata unused).
// TESTING
//  - Lone I refill: I_REQ, I_ADDR=0x0100_000; L2_ACCEPT next cycle, L2_RVALID 3 cycles later
//    with 0xA5.. -> L2_ADDR=0x0100_000, L2_WR=0, single I_RVALID with RDATA=0xA5.., no D pulses.
//  - Simultaneous I_REQ and D_REQ (refill) -> D served first, I served immediately after; one
//    response pulse each, correct RDATA routed.
//  - Starvation: I pending while D re-requests continuously -> after 4 D grants, I granted;
//    age returns to 0.
//  - D writeback: D_REQ, D_WR=1 -> D_BUSY=1 from next cycle, L2_WR=1 with D_WDATA, D_WDONE on
//    L2_WACK, D_BUSY=0 after; stray L2_RVALID during WAIT ignored.
//  - L2_ACCEPT held low 10 cycles -> L2_REQ/L2_ADDR stable throughout; duplicate I_REQ ignored.
//  - RST asserted in WAIT, then L2_RVALID arrives -> no I_RVALID/D_RVALID, all outputs 0.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// ---------------------------------------------------------------------------
// l2_arb_pkg
// Shared types and defaults for the L2 port arbiter slice.
//   state_t   : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   req_id_t  : requester identifiers (REQ_I = Icache, REQ_D = Dcache)
//   arb_pick  : arbitration decision between the two pending requesters
// ---------------------------------------------------------------------------
package l2_arb_pkg;

    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_OFFSET_WIDTH = 7;
    localparam int DEF_LINE_WIDTH   = 1024;
    localparam int DEF_AGE_MAX      = 4;
    localparam int DEF_LA           = DEF_ADDR_WIDTH - DEF_OFFSET_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    // Dcache normally wins; once the Icache has watched AGE_MAX Dcache grants
    // go by while it was waiting, it is forced through.
    function automatic req_id_t arb_pick(input logic i_cand,
                                         input logic d_pend,
                                         input logic age_full);
        if (d_pend && !(i_cand && age_full))
            return REQ_D;
        return REQ_I;
    endfunction

endpackage

// File: rtl/l2_req_latch.sv
// ---------------------------------------------------------------------------
// l2_req_latch
// Holds one requester's outstanding L2 request: a pending flag plus the
// line address, write qualifier and write line captured with the request
// pulse.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   set          one-cycle request pulse from the cache
//   clr          drop the pending request (handshake done or flush)
//   addr/wr/wdata  request fields, sampled when the pulse is taken
//   pend         request outstanding
//   addr_q/wr_q/wdata_q  captured request fields
// ---------------------------------------------------------------------------
module l2_req_latch
    import l2_arb_pkg::*;
#(
    parameter int LA = DEF_LA,
    parameter int LW = DEF_LINE_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
    input  logic          clr,
    input  logic [LA-1:0] addr,
    input  logic          wr,
    input  logic [LW-1:0] wdata,
    output logic          pend,
    output logic [LA-1:0] addr_q,
    output logic          wr_q,
    output logic [LW-1:0] wdata_q
);

    // A pulse is taken when nothing is outstanding, or when the outstanding
    // request is being cleared in this same cycle (set wins). A pulse that
    // arrives while a request is still held is dropped and the first
    // capture is kept.
    logic take;
    assign take = set & (~pend | clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            pend <= take | (pend & ~clr);
            if (take) begin
                addr_q  <= addr;
                wr_q    <= wr;
                wdata_q <= wdata;
            end
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter
// Shares the single L2 port between the Icache (line refills) and the Dcache
// (refills and dirty-line writebacks). Request pulses are latched per
// requester, one requester is granted at a time, a single L2 transaction is
// run to completion and the response pulse is routed back to the owner.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_req/i_addr/i_flush     Icache request pulse, line address, flush
//   i_rvalid                 Icache refill-done pulse
//   d_req/d_wr/d_addr/d_wdata  Dcache request pulse (wr=1 writeback), fields
//   d_rvalid/d_wdone         Dcache refill-done / writeback-done pulses
//   d_busy                   Dcache writeback pending or in flight
//   rdata                    registered L2 read line, valid with *_rvalid
//   l2_req/l2_wr/l2_addr/l2_wdata  request to the L2 controller
//   l2_accept                L2 takes the request
//   l2_rvalid/l2_rdata       L2 read data pulse and line
//   l2_wack                  L2 write complete pulse
//   dbg_state/dbg_age        FSM state and Icache aging counter
// ---------------------------------------------------------------------------
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
    parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
    parameter int AGE_MAX      = DEF_AGE_MAX
) (
    input  logic                               clk,
    input  logic                               rst,
    // Icache side
    input  logic                               i_req,
    input  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] i_addr,
    input  logic                               i_flush,
    output logic                               i_rvalid,
    // Dcache side
    input  logic                               d_req,
    input  logic                               d_wr,
    input  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0]              d_wdata,
    output logic                               d_rvalid,
    output logic                               d_wdone,
    output logic                               d_busy,
    // Shared read line
    output logic [LINE_WIDTH-1:0]              rdata,
    // L2 side
    output logic                               l2_req,
    output logic                               l2_wr,
    output logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] l2_addr,
    output logic [LINE_WIDTH-1:0]              l2_wdata,
    input  logic                               l2_accept,
    input  logic                               l2_rvalid,
    input  logic [LINE_WIDTH-1:0]              l2_rdata,
    input  logic                               l2_wack,
    // Debug visibility
    output state_t                             dbg_state,
    output logic [$clog2(AGE_MAX+1)-1:0]       dbg_age
);

    localparam int LA    = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int LW    = LINE_WIDTH;
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    // L2 request handshake: l2_req is raised with l2_wr/l2_addr/l2_wdata and
    // all four stay frozen until a cycle where l2_req & l2_accept are both
    // high; that cycle is the transfer. l2_accept outside l2_req has no
    // effect. l2_rvalid / l2_wack are single-cycle pulses that are only
    // honoured in WAIT and only when they match the transaction type.

    state_t            state;
    req_id_t           gnt;
    logic [AGE_W-1:0]  age;

    logic              i_pend, d_pend;
    logic [LA-1:0]     i_addr_q, d_addr_q;
    logic              i_wr_q, d_wr_q;
    logic [LW-1:0]     i_wdata_q, d_wdata_q;

    logic              in_issue;
    logic              handshake;
    logic              i_in_issue;
    logic              clr_i, clr_d;
    logic              i_cand;
    logic              age_full;
    req_id_t           pick;
    logic              sel_wr;
    logic [LA-1:0]     sel_addr;
    logic [LW-1:0]     sel_wdata;

    assign in_issue   = (state == ST_ISSUE);
    assign handshake  = in_issue & l2_req & l2_accept;
    assign i_in_issue = in_issue & (gnt == REQ_I);

    // A flush only drops an Icache request that has not been granted yet.
    // Once granted the transaction runs to completion.
    assign clr_i = (handshake & (gnt == REQ_I)) | (i_flush & ~i_in_issue);
    assign clr_d = handshake & (gnt == REQ_D);

    // An Icache request being flushed this very cycle must not win the
    // arbitration that happens at the same edge.
    assign i_cand   = i_pend & ~i_flush;
    assign age_full = (age == AGE_W'(AGE_MAX));
    assign pick     = arb_pick(i_cand, d_pend, age_full);

    assign sel_wr    = (pick == REQ_D) ? d_wr_q    : i_wr_q;
    assign sel_addr  = (pick == REQ_D) ? d_addr_q  : i_addr_q;
    assign sel_wdata = (pick == REQ_D) ? d_wdata_q : i_wdata_q;

    // Icache never writes: its write qualifier and line are tied off.
    l2_req_latch #(.LA(LA), .LW(LW)) u_i_latch (
        .clk     (clk),
        .rst     (rst),
        .set     (i_req),
        .clr     (clr_i),
        .addr    (i_addr),
        .wr      (1'b0),
        .wdata   ({LW{1'b0}}),
        .pend    (i_pend),
        .addr_q  (i_addr_q),
        .wr_q    (i_wr_q),
        .wdata_q (i_wdata_q)
    );

    l2_req_latch #(.LA(LA), .LW(LW)) u_d_latch (
        .clk     (clk),
        .rst     (rst),
        .set     (d_req),
        .clr     (clr_d),
        .addr    (d_addr),
        .wr      (d_wr),
        .wdata   (d_wdata),
        .pend    (d_pend),
        .addr_q  (d_addr_q),
        .wr_q    (d_wr_q),
        .wdata_q (d_wdata_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= REQ_I;
            age      <= '0;
            l2_req   <= 1'b0;
            l2_wr    <= 1'b0;
            l2_addr  <= '0;
            l2_wdata <= '0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            d_wdone  <= 1'b0;
            rdata    <= '0;
        end else begin
            // Response pulses last exactly one cycle (the RESP cycle).
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            d_wdone  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_cand | d_pend) begin
                        state    <= ST_ISSUE;
                        gnt      <= pick;
                        l2_req   <= 1'b1;
                        l2_wr    <= sel_wr;
                        l2_addr  <= sel_addr;
                        l2_wdata <= sel_wdata;
                        // Age counts Dcache grants that made a waiting
                        // Icache request wait again; an Icache grant resets it.
                        if (pick == REQ_I)
                            age <= '0;
                        else if (i_cand && !age_full)
                            age <= age + AGE_W'(1);
                    end
                end

                ST_ISSUE: begin
                    if (l2_accept) begin
                        l2_req <= 1'b0;
                        state  <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (!l2_wr && l2_rvalid) begin
                        rdata    <= l2_rdata;
                        i_rvalid <= (gnt == REQ_I);
                        d_rvalid <= (gnt == REQ_D);
                        state    <= ST_RESP;
                    end else if (l2_wr && l2_wack) begin
                        d_wdone <= 1'b1;
                        state   <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Writeback in the queue or in flight on the L2 port.
    assign d_busy = (d_pend & d_wr_q) |
                    ((state != ST_IDLE) & (gnt == REQ_D) & l2_wr);

    assign dbg_state = state;
    assign dbg_age   = age;

endmodule
